// File: rtl/mux_scan_sequencer.sv
// Scan sequencer for a 16:1 mux: steps the select over enabled channels, settles, captures, streams tagged samples.
// Optional SCAN_PARITY_EN adds smp_par, the XOR reduction of each captured word.
module mux_scan_sequencer #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             continuous,
  input  logic [15:0]      ch_mask,
  input  logic [WIDTH-1:0] mux_in,
  output logic [3:0]       sel,
  output logic [WIDTH-1:0] smp_data,
  output logic [3:0]       smp_ch,
  output logic             smp_valid,
  input  logic             smp_ready,
  output logic             busy,
  output logic             frame_done
`ifdef SCAN_PARITY_EN
  ,
  output logic             smp_par
`endif
);

  localparam int unsigned CH_W  = 4;
  localparam int unsigned N_CH  = 16;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   sel_q, sel_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic [N_CH-1:0]   mask_q, mask_d;
  logic              cont_q, cont_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_CH-1:0]   higher;
`ifdef SCAN_PARITY_EN
  logic              par_q, par_d;
`endif

  // Index of the lowest set bit; callers guarantee a nonzero mask.
  function automatic logic [CH_W-1:0] lowest_bit(input logic [N_CH-1:0] m);
    logic [CH_W-1:0] idx;
    idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (m[i]) idx = CH_W'(i);
    end
    return idx;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      mask_q  <= '0;
      cont_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef SCAN_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      mask_q  <= mask_d;
      cont_q  <= cont_d;
      cnt_q   <= cnt_d;
`ifdef SCAN_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    data_d  = data_q;
    ch_d    = ch_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    mask_d  = mask_q;
    cont_d  = cont_q;
    cnt_d   = cnt_q;
`ifdef SCAN_PARITY_EN
    par_d   = par_q;
`endif
    // Enabled channels strictly above the current select (empty when sel is 15).
    higher  = mask_q & N_CH'({1'b1, {(N_CH - 1){1'b1}}, 1'b0} << sel_q);

    case (state_q)
      IDLE: begin
        if (start && (ch_mask != '0)) begin
          mask_d  = ch_mask;
          cont_d  = continuous;
          sel_d   = lowest_bit(ch_mask);
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(SETTLE_CYC - 1)) state_d = CAPTURE;
      end
      CAPTURE: begin
        data_d  = mux_in;
        ch_d    = sel_q;
        valid_d = 1'b1;
`ifdef SCAN_PARITY_EN
        par_d   = ^mux_in;
`endif
        state_d = HOLD;
      end
      HOLD: begin
        if (valid_q && smp_ready) begin
          valid_d = 1'b0;
          if (higher != '0) begin
            sel_d   = lowest_bit(higher);
            cnt_d   = '0;
            state_d = SETTLE;
          end else begin
            done_d = 1'b1;
            if (cont_q) begin
              mask_d = ch_mask;
              if (ch_mask != '0) begin
                sel_d   = lowest_bit(ch_mask);
                cnt_d   = '0;
                state_d = SETTLE;
              end else begin
                state_d = IDLE;
              end
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign sel        = sel_q;
  assign smp_data   = data_q;
  assign smp_ch     = ch_q;
  assign smp_valid  = valid_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
`ifdef SCAN_PARITY_EN
  assign smp_par    = par_q;
`endif

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed self-checking bench for mux_scan_sequencer; a mux model feeds mux_in from the driven select.
module tb_mux_scan_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        continuous;
  logic [15:0] ch_mask;
  logic [15:0] mux_in;
  logic [3:0]  sel;
  logic [15:0] smp_data;
  logic [3:0]  smp_ch;
  logic        smp_valid;
  logic        smp_ready;
  logic        busy;
  logic        frame_done;
`ifdef SCAN_PARITY_EN
  logic        smp_par;
`endif

  logic [15:0] mux_vals [16];
  int          n_checks;
  int          n_fail;

  mux_scan_sequencer #(.WIDTH(16), .SETTLE_CYC(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .continuous (continuous),
    .ch_mask    (ch_mask),
    .mux_in     (mux_in),
    .sel        (sel),
    .smp_data   (smp_data),
    .smp_ch     (smp_ch),
    .smp_valid  (smp_valid),
    .smp_ready  (smp_ready),
    .busy       (busy),
    .frame_done (frame_done)
`ifdef SCAN_PARITY_EN
    ,
    .smp_par    (smp_par)
`endif
  );

  assign mux_in = mux_vals[sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (smp_valid) seen = 1'b1;
      else tick();
    end
    if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Waits for the next handshake, checks its payload, then checks frame_done after the edge.
  task automatic expect_sample(input string tag, input logic [3:0] ch,
                               input logic [15:0] data, input logic done);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (smp_valid && smp_ready) begin
        seen = 1'b1;
        check({tag, "_ch"}, 32'(smp_ch), 32'(ch));
        check({tag, "_data"}, 32'(smp_data), 32'(data));
        tick();
        check({tag, "_done"}, 32'(frame_done), 32'(done));
      end else begin
        tick();
      end
    end
    if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    start      = 1'b0;
    continuous = 1'b0;
    ch_mask    = '0;
    smp_ready  = 1'b0;
    for (int i = 0; i < 16; i++) mux_vals[i] = 16'(16'h1000 + i);
    mux_vals[0]  = 16'hAAAA;
    mux_vals[1]  = 16'hBBBB;
    mux_vals[5]  = 16'hFFFF;
    mux_vals[10] = 16'h1111;
    mux_vals[15] = 16'h6666;
    do_reset();

    // Reset state
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_valid", 32'(smp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_data", 32'(smp_data), 32'd0);
    check("rst_ch", 32'(smp_ch), 32'd0);

    // Single channel frame with latency check
    ch_mask   = 16'h0001;
    smp_ready = 1'b1;
    pulse_start();
    check("t1_busy", 32'(busy), 32'd1);
    tick();
    tick();
    check("t1_early_valid", 32'(smp_valid), 32'd0);
    tick();
    check("t1_valid", 32'(smp_valid), 32'd1);
    check("t1_data", 32'(smp_data), 32'hAAAA);
    check("t1_ch", 32'(smp_ch), 32'd0);
    tick();
    check("t1_done", 32'(frame_done), 32'd1);
    check("t1_valid_low", 32'(smp_valid), 32'd0);
    check("t1_busy_low", 32'(busy), 32'd0);
    tick();
    check("t1_done_pulse", 32'(frame_done), 32'd0);

    // Sparse mask including channel 15
    ch_mask = 16'h8421;
    pulse_start();
    expect_sample("t2_s0", 4'd0, 16'hAAAA, 1'b0);
    expect_sample("t2_s1", 4'd5, 16'hFFFF, 1'b0);
    expect_sample("t2_s2", 4'd10, 16'h1111, 1'b0);
    expect_sample("t2_s3", 4'd15, 16'h6666, 1'b1);
    check("t2_busy", 32'(busy), 32'd0);
    tick();
    check("t2_no_revisit", 32'(smp_valid), 32'd0);

    // Backpressure holds the sample and the select
    ch_mask   = 16'h0003;
    smp_ready = 1'b0;
    pulse_start();
    wait_valid("t3_wait");
    for (int i = 0; i < 10; i++) begin
      check("t3_hold_valid", 32'(smp_valid), 32'd1);
      check("t3_hold_data", 32'(smp_data), 32'hAAAA);
      check("t3_hold_ch", 32'(smp_ch), 32'd0);
      check("t3_hold_sel", 32'(sel), 32'd0);
      tick();
    end
    smp_ready = 1'b1;
    expect_sample("t3_s0", 4'd0, 16'hAAAA, 1'b0);
    expect_sample("t3_s1", 4'd1, 16'hBBBB, 1'b1);

    // Continuous mode, then mask cleared mid-frame ends scanning at wrap
    mux_vals[2] = 16'h2222;
    ch_mask     = 16'h0006;
    continuous  = 1'b1;
    pulse_start();
    continuous  = 1'b0;
    expect_sample("t4_f0a", 4'd1, 16'hBBBB, 1'b0);
    expect_sample("t4_f0b", 4'd2, 16'h2222, 1'b1);
    check("t4_busy_wrap", 32'(busy), 32'd1);
    expect_sample("t4_f1a", 4'd1, 16'hBBBB, 1'b0);
    expect_sample("t4_f1b", 4'd2, 16'h2222, 1'b1);
    expect_sample("t4_f2a", 4'd1, 16'hBBBB, 1'b0);
    ch_mask = 16'h0000;
    expect_sample("t4_f2b", 4'd2, 16'h2222, 1'b1);
    check("t4_idle", 32'(busy), 32'd0);
    tick();
    tick();
    tick();
    tick();
    check("t4_no_valid", 32'(smp_valid), 32'd0);

    // Start with empty mask is ignored
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_valid", 32'(smp_valid), 32'd0);
      tick();
    end

    // Start while busy has no effect
    ch_mask = 16'h0003;
    pulse_start();
    ch_mask = 16'h8000;
    tick();
    pulse_start();
    expect_sample("t6_s0", 4'd0, 16'hAAAA, 1'b0);
    expect_sample("t6_s1", 4'd1, 16'hBBBB, 1'b1);
    check("t6_idle", 32'(busy), 32'd0);

    // Reset while holding a sample
    ch_mask   = 16'h0004;
    smp_ready = 1'b0;
    pulse_start();
    wait_valid("t7_wait");
    check("t7_pre_sel", 32'(sel), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t7_valid", 32'(smp_valid), 32'd0);
    check("t7_sel", 32'(sel), 32'd0);
    check("t7_busy", 32'(busy), 32'd0);
    check("t7_data", 32'(smp_data), 32'd0);

`ifdef SCAN_PARITY_EN
    // Parity of captured words
    smp_ready   = 1'b1;
    ch_mask     = 16'h0001;
    mux_vals[0] = 16'h0001;
    pulse_start();
    wait_valid("t8_wait_a");
    check("t8_par_odd", 32'(smp_par), 32'd1);
    tick();
    mux_vals[0] = 16'h1111;
    pulse_start();
    wait_valid("t8_wait_b");
    check("t8_par_even", 32'(smp_par), 32'd0);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
